// File: rtl/cdb_arbiter_if.sv
// Producer-side result ports and CDB broadcast bundle for cdb_arbiter.
// The arbiter takes the slave view and the execute side/consumers take the master view.
interface cdb_arbiter_if #(
  parameter int unsigned RoB_WIDTH = 4,
  parameter int unsigned NUM_SRC   = 3
);
  localparam int unsigned DATA_WIDTH = 32;

  logic [NUM_SRC-1:0]            src_en;
  logic [NUM_SRC*RoB_WIDTH-1:0]  src_index;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_full;
  logic                          CDB_update_en;
  logic [RoB_WIDTH-1:0]          CDB_update_index;
  logic [DATA_WIDTH-1:0]         CDB_update_data;
  logic                          isEmpty;
  logic                          overflow_err;

  modport master (
    output src_en, src_index, src_data,
    input  src_full, CDB_update_en, CDB_update_index, CDB_update_data,
    input  isEmpty, overflow_err
  );

  modport slave (
    input  src_en, src_index, src_data,
    output src_full, CDB_update_en, CDB_update_index, CDB_update_data,
    output isEmpty, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-source result FIFOs, round-robin head selection,
// registered CDB broadcast, per-source back-pressure and sticky overflow flag.
module cdb_arbiter #(
  parameter int unsigned RoB_WIDTH  = 4,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned FIFO_WIDTH = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_signal,
  cdb_arbiter_if.slave   bus
);

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned FIFO_DEPTH  = 1 << FIFO_WIDTH;
  localparam int unsigned CNT_WIDTH   = FIFO_WIDTH + 1;
  localparam int unsigned GRANT_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [GRANT_WIDTH-1:0] LAST_SRC   = GRANT_WIDTH'(NUM_SRC - 1);
  localparam logic [CNT_WIDTH-1:0]   FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);

  // Per-source circular FIFO storage and bookkeeping
  logic [RoB_WIDTH-1:0]  idx_mem  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SRC][FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] head     [NUM_SRC];
  logic [FIFO_WIDTH-1:0] tail     [NUM_SRC];
  logic [CNT_WIDTH-1:0]  count    [NUM_SRC];

  logic [GRANT_WIDTH-1:0] last_grant;
  logic                   cdb_en_q;
  logic [RoB_WIDTH-1:0]   cdb_index_q;
  logic [DATA_WIDTH-1:0]  cdb_data_q;
  logic                   overflow_q;

  logic                   run_c;
  logic                   grant_valid_c;
  logic [GRANT_WIDTH-1:0] grant_idx_c;
  logic [RoB_WIDTH-1:0]   grant_rob_c;
  logic [DATA_WIDTH-1:0]  grant_data_c;
  logic [NUM_SRC-1:0]     deq_c;
  logic [NUM_SRC-1:0]     enq_c;
  logic [NUM_SRC-1:0]     drop_c;
  logic [NUM_SRC-1:0]     src_full_c;
  logic                   all_empty_c;

  assign run_c = rdy_in && !flush_signal;

  // Round-robin search over FIFO heads starting just after the last grant
  always_comb begin : grant_search
    logic [GRANT_WIDTH-1:0] cand;
    cand          = '0;
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    grant_rob_c   = '0;
    grant_data_c  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = GRANT_WIDTH'((32'(last_grant) + 32'd1 + i) % NUM_SRC);
      if (!grant_valid_c && (count[cand] != '0)) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = cand;
        grant_rob_c   = idx_mem[cand][head[cand]];
        grant_data_c  = data_mem[cand][head[cand]];
      end
    end
  end

  // Enqueue/dequeue decisions; a full FIFO only takes a write when its head leaves
  always_comb begin : fifo_ctrl
    logic deq_k;
    deq_k  = 1'b0;
    deq_c  = '0;
    enq_c  = '0;
    drop_c = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      deq_k    = run_c && grant_valid_c && (grant_idx_c == GRANT_WIDTH'(k));
      deq_c[k] = deq_k;
      if (run_c && bus.src_en[k]) begin
        if ((count[k] != FULL_COUNT) || deq_k) begin
          enq_c[k] = 1'b1;
        end else begin
          drop_c[k] = 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; validity lives in the counts
  always_ff @(posedge clk_in) begin : fifo_mem
    for (int k = 0; k < NUM_SRC; k++) begin
      if (enq_c[k]) begin
        idx_mem[k][tail[k]]  <= bus.src_index[k*RoB_WIDTH +: RoB_WIDTH];
        data_mem[k][tail[k]] <= bus.src_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin : fifo_state
    if (!rst_in) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        head[k]  <= '0;
        tail[k]  <= '0;
        count[k] <= '0;
      end
    end else if (flush_signal) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        head[k]  <= '0;
        tail[k]  <= '0;
        count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (enq_c[k]) begin
          tail[k] <= tail[k] + FIFO_WIDTH'(1);
        end
        if (deq_c[k]) begin
          head[k] <= head[k] + FIFO_WIDTH'(1);
        end
        if (enq_c[k] && !deq_c[k]) begin
          count[k] <= count[k] + CNT_WIDTH'(1);
        end else if (deq_c[k] && !enq_c[k]) begin
          count[k] <= count[k] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Registered broadcast; index/data hold when nothing is granted
  always_ff @(posedge clk_in or negedge rst_in) begin : cdb_regs
    if (!rst_in) begin
      cdb_en_q    <= 1'b0;
      cdb_index_q <= '0;
      cdb_data_q  <= '0;
      last_grant  <= LAST_SRC;
      overflow_q  <= 1'b0;
    end else begin
      if (|drop_c) begin
        overflow_q <= 1'b1;
      end
      if (flush_signal) begin
        cdb_en_q   <= 1'b0;
        last_grant <= LAST_SRC;
      end else if (rdy_in) begin
        if (grant_valid_c) begin
          cdb_en_q    <= 1'b1;
          cdb_index_q <= grant_rob_c;
          cdb_data_q  <= grant_data_c;
          last_grant  <= grant_idx_c;
        end else begin
          cdb_en_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin : status
    src_full_c  = '0;
    all_empty_c = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_full_c[k] = (count[k] == FULL_COUNT);
      if (count[k] != '0) begin
        all_empty_c = 1'b0;
      end
    end
  end

  assign bus.src_full         = src_full_c;
  assign bus.isEmpty          = all_empty_c && !cdb_en_q;
  assign bus.CDB_update_en    = cdb_en_q;
  assign bus.CDB_update_index = cdb_index_q;
  assign bus.CDB_update_data  = cdb_data_q;
  assign bus.overflow_err     = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin, overflow, flush, wrap, pause.
module tb_cdb_arbiter;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic flush_signal;

  int n_pass;
  int n_fail;
  int n_total;

  cdb_arbiter_if #(.RoB_WIDTH(4), .NUM_SRC(3)) bus ();

  cdb_arbiter #(.RoB_WIDTH(4), .NUM_SRC(3), .FIFO_WIDTH(2)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_signal (flush_signal),
    .bus          (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic en, input logic [3:0] idx, input logic [31:0] data);
    chk({tag, "_en"}, 32'(bus.CDB_update_en), 32'(en));
    if (en) begin
      chk({tag, "_idx"}, 32'(bus.CDB_update_index), 32'(idx));
      chk({tag, "_data"}, bus.CDB_update_data, data);
    end
  endtask

  task automatic set_src(input int k, input logic [3:0] idx, input logic [31:0] data);
    bus.src_index[k*4 +: 4]  = idx;
    bus.src_data[k*32 +: 32] = data;
  endtask

  task automatic do_reset();
    rst_in       = 1'b0;
    bus.src_en   = 3'b000;
    flush_signal = 1'b0;
    rdy_in       = 1'b1;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  initial begin
    n_pass       = 0;
    n_fail       = 0;
    n_total      = 0;
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    flush_signal = 1'b0;
    bus.src_en    = 3'b000;
    bus.src_index = '0;
    bus.src_data  = '0;
    tick();
    tick();

    // reset values
    chk("rst_en", 32'(bus.CDB_update_en), 32'd0);
    chk("rst_idx", 32'(bus.CDB_update_index), 32'd0);
    chk("rst_data", bus.CDB_update_data, 32'd0);
    chk("rst_empty", 32'(bus.isEmpty), 32'd1);
    chk("rst_full", 32'(bus.src_full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    rst_in = 1'b1;
    tick();

    // single result: two-edge latency, one-cycle pulse
    bus.src_en = 3'b001;
    set_src(0, 4'd5, 32'h1234);
    tick();
    bus.src_en = 3'b000;
    chk("single_t0_en", 32'(bus.CDB_update_en), 32'd0);
    chk("single_t0_empty", 32'(bus.isEmpty), 32'd0);
    tick();
    chk_cdb("single_t1", 1'b1, 4'd5, 32'h1234);
    tick();
    chk("single_t2_en", 32'(bus.CDB_update_en), 32'd0);
    chk("single_t2_idx_hold", 32'(bus.CDB_update_index), 32'd5);
    chk("single_t2_empty", 32'(bus.isEmpty), 32'd1);

    // round-robin from reset, then again with last_grant = 2
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bus.src_en = 3'b111;
      for (int k = 0; k < 3; k++) begin
        set_src(k, 4'(pass*3 + k + 1), 32'h100 + 32'(pass*3 + k + 1));
      end
      tick();
      bus.src_en = 3'b000;
      chk("rr_t0_en", 32'(bus.CDB_update_en), 32'd0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk_cdb("rr_order", 1'b1, 4'(pass*3 + k + 1), 32'h100 + 32'(pass*3 + k + 1));
      end
      tick();
      chk("rr_idle_en", 32'(bus.CDB_update_en), 32'd0);
      chk("rr_idle_empty", 32'(bus.isEmpty), 32'd1);
    end

    // all three push six times: fills, overflow on source 2's last write
    do_reset();
    for (int n = 0; n < 19; n++) begin
      bus.src_en = (n < 6) ? 3'b111 : 3'b000;
      for (int k = 0; k < 3; k++) begin
        set_src(k, 4'(n), 32'hA000 + 32'(k*16 + n));
      end
      tick();
      if (n == 4) begin
        chk("ovf_full_pre", 32'(bus.src_full), 32'b110);
        chk("ovf_err_pre", 32'(bus.overflow_err), 32'd0);
      end
      if (n == 5) begin
        chk("ovf_full", 32'(bus.src_full), 32'b111);
        chk("ovf_err", 32'(bus.overflow_err), 32'd1);
      end
      if (n >= 1 && n <= 17) begin
        chk_cdb("ovf_drain", 1'b1, 4'((n-1)/3), 32'hA000 + 32'(((n-1)%3)*16 + (n-1)/3));
      end
      if (n == 18) begin
        chk("ovf_end_en", 32'(bus.CDB_update_en), 32'd0);
        chk("ovf_end_empty", 32'(bus.isEmpty), 32'd1);
        chk("ovf_sticky", 32'(bus.overflow_err), 32'd1);
      end
    end

    // flush with queued entries and same-edge writes; last_grant is 1 here
    for (int n = 0; n < 2; n++) begin
      bus.src_en = 3'b111;
      for (int k = 0; k < 3; k++) begin
        set_src(k, 4'(8 + n), 32'hF000 + 32'(k*16 + n));
      end
      tick();
    end
    chk_cdb("flush_pre", 1'b1, 4'd8, 32'hF020);
    flush_signal = 1'b1;
    bus.src_en   = 3'b111;
    tick();
    flush_signal = 1'b0;
    bus.src_en   = 3'b000;
    chk("flush_en", 32'(bus.CDB_update_en), 32'd0);
    chk("flush_empty", 32'(bus.isEmpty), 32'd1);
    chk("flush_full", 32'(bus.src_full), 32'd0);
    chk("flush_ovf_kept", 32'(bus.overflow_err), 32'd1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("flush_quiet", 32'(bus.CDB_update_en), 32'd0);
    end
    // last_grant returned to NUM_SRC-1, so source 0 leads again
    bus.src_en = 3'b111;
    for (int k = 0; k < 3; k++) set_src(k, 4'(7 + k), 32'h700 + 32'(k));
    tick();
    bus.src_en = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cdb("flush_rr", 1'b1, 4'(7 + k), 32'h700 + 32'(k));
    end
    tick();
    chk("flush_rr_idle", 32'(bus.CDB_update_en), 32'd0);

    // source 2 streams ten results through a depth-4 FIFO
    for (int n = 0; n < 12; n++) begin
      bus.src_en = (n < 10) ? 3'b100 : 3'b000;
      set_src(2, 4'(n), 32'hC000 + 32'(n));
      tick();
      chk("wrap_full", 32'(bus.src_full), 32'd0);
      if (n >= 1 && n <= 10) begin
        chk_cdb("wrap_stream", 1'b1, 4'(n-1), 32'hC000 + 32'(n-1));
      end else begin
        chk("wrap_idle", 32'(bus.CDB_update_en), 32'd0);
      end
    end

    // pause while a broadcast is up and two entries wait
    bus.src_en = 3'b111;
    for (int k = 0; k < 3; k++) set_src(k, 4'(k + 1), 32'hD000 + 32'(k));
    tick();
    bus.src_en = 3'b000;
    tick();
    chk_cdb("pause_pre", 1'b1, 4'd1, 32'hD000);
    rdy_in     = 1'b0;
    bus.src_en = 3'b111;
    for (int k = 0; k < 3; k++) set_src(k, 4'hE, 32'hEEEE);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_cdb("pause_hold", 1'b1, 4'd1, 32'hD000);
      chk("pause_full", 32'(bus.src_full), 32'd0);
      chk("pause_empty", 32'(bus.isEmpty), 32'd0);
    end
    rdy_in     = 1'b1;
    bus.src_en = 3'b000;
    tick();
    chk_cdb("pause_resume1", 1'b1, 4'd2, 32'hD001);
    tick();
    chk_cdb("pause_resume2", 1'b1, 4'd3, 32'hD002);
    tick();
    chk("pause_end_en", 32'(bus.CDB_update_en), 32'd0);
    chk("pause_end_empty", 32'(bus.isEmpty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
